video_vsync_wr_sched: RTL
=========================

# video_vsync_wr_sched

Bus-side write scheduler between the FPro video bus and the video address decoder (`chu_video_controller`).
- Frame-buffer writes pass through immediately.
- Writes to video-core slot registers (sprite positions, OSD, bar, gray, sync control) can be deferred. Deferred writes are held in a FIFO and released only after the next frame start, so register updates never tear a displayed frame.
- The block arbitrates the single downstream bus between live CPU traffic and the drain engine.

## Interface
Parameters:
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW entries.
- `ADDR_W`, default 21: video word-address width.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_sys_n`  in  1  asynchronous active-low reset.
- `video_cs`, `video_wr`  in  1 each  CPU bus strobe and write qualifier.
- `video_addr`  in  ADDR_W  CPU word address; bit ADDR_W-1 = 1 selects the frame buffer.
- `video_wr_data`  in  32  CPU write data.
- `defer_en`  in  1  1 = slot writes are deferred.
- `frame_start`  in  1  single-cycle pulse from the frame counter.
- `ovf_clr`  in  1  clears the sticky overflow flag.
- `out_cs`, `out_wr`  out  1 each  strobes to the decoder.
- `out_addr`  out  ADDR_W  address to the decoder.
- `out_wr_data`  out  32  data to the decoder.
- `q_count`  out  FIFO_AW+1  current FIFO occupancy.
- `draining`  out  1  high while in the DRAIN state.
- `overflow`  out  1  sticky; set when a deferred write is dropped.

## Operation
- Classify each CPU cycle (video_cs=1):
  - FB: addr MSB = 1.
  - SLOT_WR: addr MSB = 0 and video_wr = 1.
  - SLOT_RD: addr MSB = 0 and video_wr = 0.
- FB and SLOT_RD always pass through.
- SLOT_WR is enqueued when defer_en = 1 **or** q_count ≠ 0. Once a write is queued, ordering of slot writes is preserved even after defer_en drops. Otherwise SLOT_WR passes through.
- Enqueue while full: the write is dropped and overflow is set. overflow is cleared only by ovf_clr; if set and clear occur in the same cycle, set wins.
- FSM states: IDLE, DRAIN.
  - IDLE → DRAIN on frame_start when q_count ≠ 0. At that moment drain_left is loaded with q_count.
  - frame_start with an empty queue stays in IDLE.
  - In DRAIN, each granted drain cycle pops one entry, drives it out with out_cs = out_wr = 1, and decrements drain_left.
  - DRAIN → IDLE in the cycle after drain_left reaches 0.
  - Entries enqueued during DRAIN are not counted in drain_left. They wait for the next frame_start.
  - frame_start while in DRAIN is ignored.
- Arbitration: a CPU pass-through has fixed priority over the drain. The drain stalls in any cycle where a pass-through occurs.
- Enqueue and pop in the same cycle are both performed; q_count is unchanged.
- The drain pops regardless of the current value of defer_en.

## Timing
- All outputs are registered: a pass-through or a drained entry appears on out_* exactly 1 cycle after its input or grant cycle.
- out_* are valid for a single cycle. In cycles with no pass-through and no drain grant, out_cs = 0.
- Drain throughput: 1 entry per cycle when the CPU is idle. The first drained write appears 2 cycles after frame_start (state load, then registered output).
- q_count and overflow update at the clock edge after the enqueue/pop cycle.
- Reset values: out_cs = 0, out_wr = 0, out_addr = 0, out_wr_data = 0, q_count = 0, draining = 0, overflow = 0, state = IDLE, drain_left = 0. FIFO pointers are cleared.
- Reset asserted mid-drain: all queued writes are discarded and no partial output is produced after reset releases.

## Structure
- Package `video_sched_pkg`:
  - `sched_state_t` enum (IDLE, DRAIN).
  - `vwr_entry_t` packed struct {addr[ADDR_W-1:0], data[31:0]}.
  - Constant `FB_SEL_BIT = ADDR_W-1`.
- Sub-module `vsched_fifo`: synchronous FIFO with registered count, full/empty flags, and async active-low reset. The top level holds the classifier, FSM, drain_left counter, arbiter, and output register.

## Test plan
- defer_en = 0, slot write to addr 0x00401, data 0xABCD → out_* shows 0x00401/0xABCD after 1 cycle; q_count stays 0.
- defer_en = 1, three slot writes (0x00C00, 0x00C01, 0x00C02) → no out_cs; q_count = 3. On frame_start, the writes appear in order on cycles +2, +3, +4; draining falls after the last.
- During a drain, a CPU FB write to 0x100010 in the same cycle as a grant → the FB write is output first, the drain entry is delayed by 1 cycle, and no entry is lost or reordered.
- defer_en = 1 with FIFO_AW = 4, 17 slot writes → q_count = 16 and overflow = 1. ovf_clr asserted with a simultaneous 18th write → overflow stays 1.
- Two entries queued, frame_start, then a new slot write during DRAIN → only 2 entries drain; q_count = 1 afterwards. The entry drains on the next frame_start.
- Assert reset_sys_n low mid-drain with 5 queued → out_cs = 0 and q_count = 0 immediately. A frame_start after release produces no output.

Source files
------------

// File: rtl/video_sched_pkg.sv
// Shared types and constants for the vsync-deferred video write scheduler.
//   sched_state_t : drain FSM states
//   vwr_entry_t   : one deferred slot write {addr, data} at the default address width
//   FB_SEL_BIT    : address bit that selects the frame buffer
package video_sched_pkg;

  localparam int PKG_ADDR_W = 21;
  localparam int FB_SEL_BIT = PKG_ADDR_W - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [31:0]           data;
  } vwr_entry_t;

endpackage

// File: rtl/vsched_fifo.sv
// Synchronous FIFO holding deferred slot writes.
// Ports:
//   clk_sys, reset_sys_n : clock, asynchronous active-low reset (clears pointers/count)
//   push, wr_data        : enqueue request and entry (ignored when full)
//   pop, rd_data         : dequeue request and show-ahead head entry (ignored when empty)
//   count, full, empty   : registered occupancy and flags
module vsched_fifo #(
  parameter int AW = 4,
  parameter int W  = 53
) (
  input  logic          clk_sys,
  input  logic          reset_sys_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/video_vsync_wr_sched.sv
// Bus-side write scheduler in front of the video address decoder.
// Frame-buffer accesses and slot reads pass straight through; slot writes are
// queued while deferral is enabled (or while older writes are still queued) and
// drained after the next frame start so register updates never tear a frame.
// Ports:
//   clk_sys, reset_sys_n            : clock, asynchronous active-low reset
//   video_cs/wr/addr/wr_data        : CPU bus request
//   defer_en                        : defer slot writes
//   frame_start                     : one-cycle frame pulse, triggers a drain
//   ovf_clr                         : clears the sticky overflow flag
//   out_cs/wr/addr/wr_data          : registered request to the decoder
//   q_count, draining, overflow     : status
module video_vsync_wr_sched
  import video_sched_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int ADDR_W  = 21
) (
  input  logic              clk_sys,
  input  logic              reset_sys_n,
  input  logic              video_cs,
  input  logic              video_wr,
  input  logic [ADDR_W-1:0] video_addr,
  input  logic [31:0]       video_wr_data,
  input  logic              defer_en,
  input  logic              frame_start,
  input  logic              ovf_clr,
  output logic              out_cs,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_wr_data,
  output logic [FIFO_AW:0]  q_count,
  output logic              draining,
  output logic              overflow
);

  localparam int ENT_W = ADDR_W + 32;

  sched_state_t       state, state_nxt;
  logic [FIFO_AW:0]   drain_left, drain_left_nxt;
  logic               slot_wr, enq_req, pass_thru, grant;
  logic               fifo_full, fifo_empty;
  logic [ENT_W-1:0]   fifo_rd;

  // Once anything is queued, later slot writes must queue behind it to keep order.
  assign slot_wr   = video_cs && video_wr && !video_addr[ADDR_W-1];
  assign enq_req   = slot_wr && (defer_en || (q_count != '0));
  assign pass_thru = video_cs && !enq_req;
  // CPU pass-through owns the bus; the drain only gets idle cycles.
  assign grant     = (state == DRAIN) && (drain_left != '0) && !pass_thru && !fifo_empty;
  assign draining  = (state == DRAIN);

  vsched_fifo #(
    .AW (FIFO_AW),
    .W  (ENT_W)
  ) u_fifo (
    .clk_sys     (clk_sys),
    .reset_sys_n (reset_sys_n),
    .push        (enq_req),
    .wr_data     ({video_addr, video_wr_data}),
    .pop         (grant),
    .rd_data     (fifo_rd),
    .count       (q_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // drain_left snapshots the queue at frame start so writes arriving
  // mid-drain wait for the following frame.
  always_comb begin
    state_nxt      = state;
    drain_left_nxt = drain_left;
    case (state)
      IDLE: begin
        if (frame_start && (q_count != '0)) begin
          state_nxt      = DRAIN;
          drain_left_nxt = q_count;
        end
      end
      DRAIN: begin
        if (drain_left == '0)
          state_nxt = IDLE;
        else if (grant)
          drain_left_nxt = drain_left - (FIFO_AW+1)'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      state      <= IDLE;
      drain_left <= '0;
    end else begin
      state      <= state_nxt;
      drain_left <= drain_left_nxt;
    end
  end

  // A drop sets the flag even if a clear arrives in the same cycle.
  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n)
      overflow <= 1'b0;
    else if (enq_req && fifo_full)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  // Output stage: one registered bus cycle per pass-through or drain grant.
  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      out_cs      <= 1'b0;
      out_wr      <= 1'b0;
      out_addr    <= '0;
      out_wr_data <= '0;
    end else if (pass_thru) begin
      out_cs      <= 1'b1;
      out_wr      <= video_wr;
      out_addr    <= video_addr;
      out_wr_data <= video_wr_data;
    end else if (grant) begin
      out_cs      <= 1'b1;
      out_wr      <= 1'b1;
      out_addr    <= fifo_rd[ENT_W-1:32];
      out_wr_data <= fifo_rd[31:0];
    end else begin
      out_cs      <= 1'b0;
      out_wr      <= 1'b0;
    end
  end

endmodule
